// File: rtl/clk_tick_gen.sv
// clk_tick_gen: multi-channel programmable clock-enable generator (one-cycle tick plus 50% square wave).
// Optional single-step logic is built only when the macro CLKDIV_STEP_EN is defined.
module clk_tick_gen #(
  parameter int WIDTH       = 24,
  parameter int CHANNELS    = 2,
  parameter int DEFAULT_DIV = 131072,
  parameter int SEL_W       = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [WIDTH-1:0]    cfg_div,
  output logic [CHANNELS-1:0] cfg_busy,
  output logic [CHANNELS-1:0] tick_o,
  output logic [CHANNELS-1:0] div_o,
  input  logic                step_mode,
  input  logic                step_req
);

  localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

  // Config port: cfg_we is a one-cycle strobe with no ready; a write is always
  // accepted on the edge that samples it, and cfg_busy shows it is not yet applied.

  logic step_hold;
  logic step_fire;

`ifdef CLKDIV_STEP_EN
  logic step_req_q;

  always_ff @(posedge clk) begin
    if (reset) step_req_q <= 1'b0;
    else       step_req_q <= step_req;
  end

  assign step_hold = step_mode;
  assign step_fire = step_mode & step_req & ~step_req_q;
`else
  logic unused_step;
  assign unused_step = step_mode ^ step_req;
  assign step_hold   = 1'b0;
  assign step_fire   = 1'b0;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic [WIDTH-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             div_q, div_d;
    logic             wr;
    logic             enabled;
    logic             wrap;

    assign wr      = cfg_we && (cfg_sel == SEL_W'(g));
    assign enabled = (act_q != '0);
    assign wrap    = enabled && (step_hold ? step_fire : (cnt_q == act_q - WIDTH'(1)));

    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      pdiv_d = pdiv_q;
      pend_d = pend_q;
      tick_d = 1'b0;
      div_d  = div_q;
      if (!enabled) begin
        cnt_d = '0;
        if (pend_q) begin
          act_d  = pdiv_q;
          pend_d = 1'b0;
        end
      end else if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        div_d  = ~div_q;
        if (pend_q) begin
          act_d  = pdiv_q;
          pend_d = 1'b0;
        end
      end else if (step_hold) begin
        // Parked at zero so free-running resumes with a full period.
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
      // A write on the wrap edge lands after the old pending value is consumed.
      if (wr) begin
        pdiv_d = cfg_div;
        pend_d = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q  <= '0;
        act_q  <= RESET_DIV;
        pdiv_q <= RESET_DIV;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        div_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        pdiv_q <= pdiv_d;
        pend_q <= pend_d;
        tick_q <= tick_d;
        div_q  <= div_d;
      end
    end

    assign cfg_busy[g] = pend_q;
    assign tick_o[g]   = tick_q;
    assign div_o[g]    = div_q;
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Testbench for clk_tick_gen: directed scenarios plus randomized traffic checked against
// a tick-schedule reference model. Step-mode scenario is built when CLKDIV_STEP_EN is defined.
module tb_clk_tick_gen;
  localparam int WIDTH       = 8;
  localparam int CHANNELS    = 2;
  localparam int DEFAULT_DIV = 4;
  localparam int SEL_W       = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic                cfg_we;
  logic [SEL_W-1:0]    cfg_sel;
  logic [WIDTH-1:0]    cfg_div;
  logic [CHANNELS-1:0] cfg_busy;
  logic [CHANNELS-1:0] tick_o;
  logic [CHANNELS-1:0] div_o;
  logic                step_mode;
  logic                step_req;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  clk_tick_gen #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEFAULT_DIV(DEFAULT_DIV), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_div(cfg_div),
    .cfg_busy(cfg_busy), .tick_o(tick_o), .div_o(div_o),
    .step_mode(step_mode), .step_req(step_req)
  );

  // Reference model: each channel keeps the absolute edge number of its next tick.
  int n;
  int m_d[CHANNELS];
  int m_pd[CHANNELS];
  int m_next[CHANNELS];
  bit m_pend[CHANNELS];
  bit m_tick[CHANNELS];
  bit m_div[CHANNELS];
  bit m_prev_req;
  logic [7:0] exp_q[$];

  function automatic logic [3*CHANNELS-1:0] exp_vec();
    logic [CHANNELS-1:0] b, d, t;
    for (int c = 0; c < CHANNELS; c++) begin
      b[c] = m_pend[c];
      d[c] = m_div[c];
      t[c] = m_tick[c];
    end
    return {b, d, t};
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (reset) begin
      n = 0;
      m_prev_req = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        m_d[c] = DEFAULT_DIV; m_pd[c] = DEFAULT_DIV; m_pend[c] = 1'b0;
        m_tick[c] = 1'b0; m_div[c] = 1'b0; m_next[c] = DEFAULT_DIV;
      end
    end else begin
      n++;
      for (int c = 0; c < CHANNELS; c++) begin
        bit fire;
        fire = (n == m_next[c]);
`ifdef CLKDIV_STEP_EN
        if (step_mode) fire = step_req && !m_prev_req;
`endif
        m_tick[c] = 1'b0;
        if (m_d[c] == 0) begin
          if (m_pend[c]) begin m_d[c] = m_pd[c]; m_pend[c] = 1'b0; end
          m_next[c] = n + m_d[c];
        end else if (fire) begin
          m_tick[c] = 1'b1;
          m_div[c]  = !m_div[c];
          if (m_pend[c]) begin m_d[c] = m_pd[c]; m_pend[c] = 1'b0; end
          m_next[c] = n + m_d[c];
        end
`ifdef CLKDIV_STEP_EN
        if (step_mode) m_next[c] = n + m_d[c];
`endif
        if (cfg_we && int'(cfg_sel) == c) begin
          m_pd[c] = int'(cfg_div); m_pend[c] = 1'b1;
        end
      end
      m_prev_req = step_req;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_div = '0;
    step_mode = 1'b0; step_req = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_we = 1'b1; cfg_sel = '0; cfg_div = 8'd9;
    step_mode = 1'b0; step_req = 1'b0;
    repeat (3) cyc();
    cfg_we = 1'b0;
    vectors++;
    if ({cfg_busy, div_o, tick_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want 0", {cfg_busy, div_o, tick_o});
    end
  endtask

  task automatic test_free_run();
    do_reset();
    exp_q = '{8'd4, 8'd8, 8'd12};
    for (int k = 0; k < 13; k++) begin
      cyc();
      vectors++;
      if ({cfg_busy, div_o, tick_o} !== exp_vec()) begin
        miscompares++;
        $display("FAIL free_run_model n=%0d got %b want %b", n, {cfg_busy, div_o, tick_o}, exp_vec());
      end
      vectors++;
      if (tick_o[0] !== (exp_q.size() > 0 && n == int'(exp_q[0]))) begin
        miscompares++;
        $display("FAIL free_run_tick n=%0d got %b", n, tick_o[0]);
      end
      if (exp_q.size() > 0 && n == int'(exp_q[0])) void'(exp_q.pop_front());
      vectors++;
      if (div_o[0] !== 1'((n / 4) % 2)) begin
        miscompares++;
        $display("FAIL free_run_div n=%0d got %b want %0d", n, div_o[0], (n / 4) % 2);
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL free_run_missing_ticks got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_update();
    do_reset();
    for (int k = 0; k < 30; k++) begin
      int e;
      e = n + 1;
      cfg_we  = (e == 1) || (e == 2) || (e == 7);
      cfg_sel = (e == 2) ? 3'd1 : 3'd0;
      cfg_div = (e == 7) ? 8'd3 : 8'd8;
      cyc();
      vectors++;
      if ({cfg_busy, div_o, tick_o} !== exp_vec()) begin
        miscompares++;
        $display("FAIL update_model n=%0d got %b want %b", n, {cfg_busy, div_o, tick_o}, exp_vec());
      end
      vectors++;
      if (n >= 5 && cfg_busy[0] !== (n >= 7 && n < 12)) begin
        miscompares++;
        $display("FAIL update_busy n=%0d got %b", n, cfg_busy[0]);
      end
      vectors++;
      if (n >= 5 && tick_o !== {1'(n == 12 || n == 20 || n == 28), 1'(n >= 12 && (n - 12) % 3 == 0)}) begin
        miscompares++;
        $display("FAIL update_ticks n=%0d got %b", n, tick_o);
      end
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_disable();
    do_reset();
    for (int k = 0; k < 22; k++) begin
      int e;
      e = n + 1;
      cfg_we  = (e == 2) || (e == 10);
      cfg_sel = 3'd0;
      cfg_div = (e == 10) ? 8'd5 : 8'd0;
      cyc();
      vectors++;
      if ({cfg_busy, div_o, tick_o} !== exp_vec()) begin
        miscompares++;
        $display("FAIL disable_model n=%0d got %b want %b", n, {cfg_busy, div_o, tick_o}, exp_vec());
      end
      vectors++;
      if ({cfg_busy[0], div_o[0], tick_o[0]} !==
          {1'((n >= 2 && n < 4) || n == 10), 1'((n >= 4 && n < 16) || n >= 21), 1'(n == 4 || n == 16 || n == 21)}) begin
        miscompares++;
        $display("FAIL disable_ch0 n=%0d got busy/div/tick %b%b%b", n, cfg_busy[0], div_o[0], tick_o[0]);
      end
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_boundaries();
    do_reset();
    for (int k = 0; k < 14; k++) begin
      int e;
      e = n + 1;
      cfg_we  = (e == 1) || (e == 5) || (e == 6) || (e == 7);
      cfg_sel = (e == 1) ? 3'd0 : (e == 7) ? 3'd5 : 3'd1;
      cfg_div = (e == 1) ? 8'd1 : (e == 5) ? 8'd6 : (e == 6) ? 8'd2 : 8'd9;
      cyc();
      vectors++;
      if ({cfg_busy, div_o, tick_o} !== exp_vec()) begin
        miscompares++;
        $display("FAIL boundary_model n=%0d got %b want %b", n, {cfg_busy, div_o, tick_o}, exp_vec());
      end
      vectors++;
      if (n >= 4 && (tick_o[0] !== 1'b1 || div_o[0] !== 1'((n - 3) % 2))) begin
        miscompares++;
        $display("FAIL boundary_div1 n=%0d got tick/div %b%b", n, tick_o[0], div_o[0]);
      end
      vectors++;
      if (tick_o[1] !== 1'(n == 4 || (n >= 8 && n % 2 == 0))) begin
        miscompares++;
        $display("FAIL boundary_last_write n=%0d got %b", n, tick_o[1]);
      end
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      reset   = (k == 10);
      cfg_we  = (k == 1) || (k == 7);
      cfg_sel = 3'd0;
      cfg_div = (k == 1) ? 8'd7 : 8'd3;
      cyc();
      vectors++;
      if ({cfg_busy, div_o, tick_o} !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_mid_model k=%0d got %b want %b", k, {cfg_busy, div_o, tick_o}, exp_vec());
      end
      vectors++;
      if (k >= 10 && tick_o[0] !== 1'(k > 10 && (k - 10) % DEFAULT_DIV == 0)) begin
        miscompares++;
        $display("FAIL reset_mid_tick k=%0d got %b", k, tick_o[0]);
      end
      vectors++;
      if (k == 10 && {cfg_busy, div_o, tick_o} !== '0) begin
        miscompares++;
        $display("FAIL reset_mid_zero got %b want 0", {cfg_busy, div_o, tick_o});
      end
    end
    reset = 1'b0; cfg_we = 1'b0;
  endtask

`ifdef CLKDIV_STEP_EN
  task automatic test_step();
    do_reset();
    while (n < 146) begin
      int e;
      e = n + 1;
      cfg_we    = (e == 1);
      cfg_sel   = 3'd0;
      cfg_div   = 8'd100;
      step_mode = (e >= 5 && e < 45);
      step_req  = (e == 8) || (e == 12) || (e == 16) || (e >= 20 && e < 40);
      cyc();
      vectors++;
      if ({cfg_busy, div_o, tick_o} !== exp_vec()) begin
        miscompares++;
        $display("FAIL step_model n=%0d got %b want %b", n, {cfg_busy, div_o, tick_o}, exp_vec());
      end
      vectors++;
      if (tick_o[0] !== 1'(n inside {4, 8, 12, 16, 20, 144})) begin
        miscompares++;
        $display("FAIL step_tick n=%0d got %b", n, tick_o[0]);
      end
    end
    step_mode = 1'b0; step_req = 1'b0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      reset   = ($urandom_range(0, 299) == 0);
      cfg_we  = ($urandom_range(0, 7) == 0);
      cfg_sel = SEL_W'($urandom_range(0, 3));
      cfg_div = WIDTH'($urandom_range(0, 6));
`ifdef CLKDIV_STEP_EN
      if ($urandom_range(0, 63) == 0) step_mode = !step_mode;
      step_req = ($urandom_range(0, 3) == 0);
`endif
      cyc();
      vectors++;
      if ({cfg_busy, div_o, tick_o} !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_model k=%0d n=%0d got %b want %b", k, n, {cfg_busy, div_o, tick_o}, exp_vec());
      end
    end
    reset = 1'b0; cfg_we = 1'b0; step_mode = 1'b0; step_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_update();
    test_disable();
    test_boundaries();
    test_reset_mid();
`ifdef CLKDIV_STEP_EN
    test_step();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
